// File: rtl/spi_pkg.sv
// spi_pkg: shared SPI mode encodings, FSM states and CRC-8 step function
package spi_pkg;
   typedef enum logic [1:0] {SPI_MODE0, SPI_MODE1, SPI_MODE2, SPI_MODE3} spi_mode_e;
   typedef enum logic {IDLE, ACTIVE} state_e;
   localparam logic [7:0] CRC8_POLY = 8'h07;
   function automatic logic [7:0] crc8_bit(input logic [7:0] c, input logic b);
      return {c[6:0], 1'b0} ^ ((c[7] ^ b) ? CRC8_POLY : 8'h00);
   endfunction
endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: multi-flop synchronizer with registered rise/fall pulses
module spi_sync_edge #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q,
   output logic rise,
   output logic fall
);
   logic [STAGES-1:0] sr;
   logic              q_d;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sr  <= '0;
         q_d <= 1'b0;
      end else begin
         sr  <= {sr[STAGES-2:0], d};
         q_d <= q;
      end
   end
   assign q    = sr[STAGES-1];
   assign rise = q & ~q_d;
   assign fall = ~q & q_d;
endmodule

// File: rtl/spi_slave_os.sv
// spi_slave_os: oversampled SPI slave, all four modes; SPI_CRC8_EN adds a crc8 output
module spi_slave_os
   import spi_pkg::*;
#(
   parameter int DATA_W      = 8,
   parameter int CNT_W       = 32,
   parameter int SYNC_STAGES = 2
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       cpol,
   input  logic                       cpha,
   input  logic                       SCK,
   input  logic                       MOSI,
   input  logic                       SSEL,
   output logic                       MISO,
   output logic                       miso_oe,
   output logic                       cmd_ready,
   output logic                       param_ready,
   output logic [DATA_W-1:0]          cmd_data,
   output logic [DATA_W-1:0]          param_data,
   output logic [CNT_W-1:0]           byte_cnt,
   output logic [$clog2(DATA_W)-1:0]  bit_cnt,
   input  logic [DATA_W-1:0]          tx_data,
   output logic                       tx_ack
`ifdef SPI_CRC8_EN
   ,output logic [7:0]                crc8
`endif
);
   localparam int BW = $clog2(DATA_W);
   logic sck_s, sck_rise, sck_fall, ssel_s, ssel_rise, ssel_fall, mosi_s;
   logic [SYNC_STAGES-1:0] mosi_sr;
   logic cpol_q, cpha_q, skip, samp_hi, sample, shift, last, start, stop, act;
   logic [DATA_W-2:0] rx_sr;
   logic [DATA_W-1:0] tx_sr, word;
   spi_mode_e mode;
   state_e state, state_nx;
   spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sck (
      .clk(clk), .rst_n(rst_n), .d(SCK), .q(sck_s), .rise(sck_rise), .fall(sck_fall));
   spi_sync_edge #(.STAGES(SYNC_STAGES)) u_ssel (
      .clk(clk), .rst_n(rst_n), .d(SSEL), .q(ssel_s), .rise(ssel_rise), .fall(ssel_fall));
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mosi_sr <= '0;
         cpol_q  <= 1'b0;
         cpha_q  <= 1'b0;
      end else begin
         mosi_sr <= {mosi_sr[SYNC_STAGES-2:0], MOSI};
         if (ssel_s) {cpol_q, cpha_q} <= {cpol, cpha};
      end
   end
   assign mosi_s = mosi_sr[SYNC_STAGES-1];
   // modes 0 and 3 sample on the rising SCK edge, modes 1 and 2 on the falling one
   assign mode    = spi_mode_e'({cpol_q, cpha_q});
   assign samp_hi = (mode == SPI_MODE0) || (mode == SPI_MODE3);
   assign sample  = (sck_rise | sck_fall) & (sck_s == samp_hi);
   assign shift   = (sck_rise | sck_fall) & (sck_s != samp_hi);
   assign last    = bit_cnt == BW'(DATA_W - 1);
   assign word    = {rx_sr, mosi_s};
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end
   always_comb begin
      state_nx = ssel_rise ? IDLE : (state == IDLE && ssel_fall) ? ACTIVE : state;
   end
   always_comb begin
      start   = (state == IDLE) & ssel_fall;
      stop    = (state == ACTIVE) & ssel_rise;
      act     = (state == ACTIVE) & ~ssel_rise;
      miso_oe = state == ACTIVE;
      MISO    = tx_sr[DATA_W-1];
      tx_ack  = start | (act & sample & last);
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cmd_ready   <= 1'b0;
         param_ready <= 1'b0;
         cmd_data    <= '0;
         param_data  <= '0;
         byte_cnt    <= '0;
         bit_cnt     <= '0;
         rx_sr       <= '0;
         tx_sr       <= '0;
         skip        <= 1'b0;
      end else begin
         cmd_ready   <= 1'b0;
         param_ready <= 1'b0;
         if (stop) begin
            bit_cnt  <= '0;
            byte_cnt <= '0;
         end else if (start) begin
            cmd_data <= '0;
            bit_cnt  <= '0;
            byte_cnt <= '0;
            rx_sr    <= '0;
            tx_sr    <= tx_data;
            skip     <= cpha_q;
         end else if (act && sample) begin
            rx_sr   <= word[DATA_W-2:0];
            bit_cnt <= last ? '0 : bit_cnt + 1'b1;
            if (last) begin
               if (byte_cnt == '0) {cmd_data, cmd_ready} <= {word, 1'b1};
               else                {param_data, param_ready} <= {word, 1'b1};
               byte_cnt <= &byte_cnt ? byte_cnt : byte_cnt + 1'b1;
               tx_sr    <= tx_data;
               skip     <= 1'b1;
            end
         end else if (act && shift) begin
            tx_sr <= skip ? tx_sr : {tx_sr[DATA_W-2:0], 1'b0};
            skip  <= 1'b0;
         end
      end
   end
`ifdef SPI_CRC8_EN
   logic [7:0] crc_run, crc_nx;
   assign crc_nx = crc8_bit(crc_run, mosi_s);
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         crc_run <= '0;
         crc8    <= '0;
      end else if (stop) begin
         crc_run <= crc8;
      end else if (start) begin
         crc_run <= '0;
         crc8    <= '0;
      end else if (act && sample) begin
         crc_run <= crc_nx;
         if (last) crc8 <= crc_nx;
      end
   end
`endif
endmodule

// File: tb/tb_spi_slave_os.sv
// tb_spi_slave_os: randomized SPI master driving spi_slave_os against a message-level model
module tb_spi_slave_os;
   logic clk = 1'b0;
   logic rst_n, cpol, cpha, SCK, MOSI, SSEL;
   logic MISO, miso_oe, cmd_ready, param_ready, tx_ack;
   logic [7:0] cmd_data, param_data, tx_data;
   logic [31:0] byte_cnt;
   logic [2:0] bit_cnt;
   int checks = 0, failures = 0, acks = 0, hp = 6;
   logic [7:0] mq[$], tq[$], cmd_q[$], par_q[$];
`ifdef SPI_CRC8_EN
   logic [7:0] crc8, crc_seen;
`endif
   spi_slave_os #(.DATA_W(8), .CNT_W(32), .SYNC_STAGES(2)) dut (
      .clk(clk), .rst_n(rst_n), .cpol(cpol), .cpha(cpha), .SCK(SCK), .MOSI(MOSI),
      .SSEL(SSEL), .MISO(MISO), .miso_oe(miso_oe), .cmd_ready(cmd_ready),
      .param_ready(param_ready), .cmd_data(cmd_data), .param_data(param_data),
      .byte_cnt(byte_cnt), .bit_cnt(bit_cnt), .tx_data(tx_data), .tx_ack(tx_ack)
`ifdef SPI_CRC8_EN
      , .crc8(crc8)
`endif
   );
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask
   function automatic logic [7:0] crc_ref(input logic [7:0] ws[$]);
      logic [7:0] c = 8'h00;
      foreach (ws[i]) begin
         c = c ^ ws[i];
         for (int k = 0; k < 8; k++) c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
      end
      return c;
   endfunction
   initial begin
      forever begin
         @(negedge clk);
         if (cmd_ready) cmd_q.push_back(cmd_data);
         if (param_ready) par_q.push_back(param_data);
`ifdef SPI_CRC8_EN
         if (cmd_ready || param_ready) crc_seen = crc8;
`endif
      end
   end
   // transmit side of the command decoder: present the head word, pop it once acked
   initial begin
      tx_data = 8'h00;
      forever begin
         @(negedge clk);
         tx_data = (tq.size() > 0) ? tq[0] : 8'h00;
         if (tx_ack) begin
            acks++;
            @(posedge clk);
            #1;
            if (tq.size() > 0) void'(tq.pop_front());
            tx_data = (tq.size() > 0) ? tq[0] : 8'h00;
         end
      end
   end
   task automatic xfer(input logic p, input logic h, input int abort_bits, input bit chg);
      int nw = mq.size();
      int a0;
      logic [7:0] te[$];
      logic [7:0] rx;
      cmd_q.delete();
      par_q.delete();
      tq.delete();
      for (int i = 0; i <= nw; i++) tq.push_back(8'($urandom));
      te = tq;
      cpol = p; cpha = h; SCK = p;
      tick(4);
      a0 = acks;
      SSEL = 1'b0;
      tick(hp);
      for (int w = 0; w < nw + (abort_bits > 0 ? 1 : 0); w++) begin
         int nb = (w < nw) ? 8 : abort_bits;
         rx = 8'h00;
         if (chg && w == 1) cpol = ~p;
         for (int b = 0; b < nb; b++) begin
            logic bit_v = (w < nw) ? mq[w][7-b] : 1'($urandom);
            if (!h) begin
               MOSI = bit_v; tick(hp); SCK = ~p; rx = {rx[6:0], MISO}; tick(hp); SCK = p;
            end else begin
               SCK = ~p; MOSI = bit_v; tick(hp); SCK = p; rx = {rx[6:0], MISO}; tick(hp);
            end
         end
         if (w < nw) check("miso_word", rx, te[w]);
      end
      tick(hp);
      check("byte_cnt_pre", byte_cnt, nw);
      check("miso_oe_act", miso_oe, 1);
      SSEL = 1'b1;
      tick(6);
      check("byte_cnt_post", byte_cnt, 0);
      check("bit_cnt_post", bit_cnt, 0);
      check("miso_oe_idle", miso_oe, 0);
      check("cmd_cnt", cmd_q.size(), nw > 0 ? 1 : 0);
      if (nw > 0) check("cmd_data", cmd_q[0], mq[0]);
      check("par_cnt", par_q.size(), nw > 0 ? nw - 1 : 0);
      for (int k = 1; k < nw; k++) check("par_data", par_q[k-1], mq[k]);
      check("tx_acks", acks - a0, nw + 1);
`ifdef SPI_CRC8_EN
      if (nw > 0) check("crc8", crc_seen, crc_ref(mq));
`endif
   endtask
   initial begin
      rst_n = 1'b0; SSEL = 1'b1; SCK = 1'b0; MOSI = 1'b0; cpol = 1'b0; cpha = 1'b0;
      tick(3);
      check("rst_cmd_data", cmd_data, 0);
      check("rst_byte_cnt", byte_cnt, 0);
      check("rst_miso", {MISO, miso_oe, cmd_ready, param_ready, tx_ack}, 0);
      rst_n = 1'b1;
      tick(4);
      mq = '{8'hA5, 8'h3C, 8'h01};
      xfer(1'b0, 1'b0, 0, 1'b0);
      mq = '{8'h6E, 8'h11};
      xfer(1'b1, 1'b1, 0, 1'b0);
      mq = '{8'hC3};
      xfer(1'b0, 1'b1, 0, 1'b0);
      mq = '{8'hC3};
      xfer(1'b1, 1'b0, 0, 1'b0);
      mq = '{8'h81, 8'h7F};
      xfer(1'b0, 1'b0, 5, 1'b0);
      mq = '{8'h3D, 8'hE2};
      xfer(1'b0, 1'b0, 0, 1'b1);
      mq = '{8'h31, 8'h32};
      xfer(1'b1, 1'b1, 0, 1'b0);
      for (int r = 0; r < 12; r++) begin
         mq.delete();
         for (int i = 0; i < $urandom_range(1, 4); i++) mq.push_back(8'($urandom));
         hp = $urandom_range(4, 7);
         xfer(1'($urandom), 1'($urandom), ($urandom_range(0, 2) == 0) ? $urandom_range(1, 7) : 0, 1'($urandom));
      end
      hp = 6;
      cpol = 1'b0; cpha = 1'b0; SCK = 1'b0;
      tick(4);
      SSEL = 1'b0;
      tick(hp);
      for (int b = 0; b < 3; b++) begin
         MOSI = 1'b1; tick(hp); SCK = 1'b1; tick(hp); SCK = 1'b0;
      end
      tick(hp);
      check("pre_rst_bit_cnt", bit_cnt, 3);
      rst_n = 1'b0;
      #2;
      check("arst_bit_cnt", bit_cnt, 0);
      check("arst_cmd_data", cmd_data, 0);
      check("arst_param_data", param_data, 0);
      check("arst_outs", {MISO, miso_oe, cmd_ready, param_ready, tx_ack}, 0);
      SSEL = 1'b1;
      tick(3);
      rst_n = 1'b1;
      tick(4);
      mq = '{8'h5E, 8'h90};
      xfer(1'b0, 1'b0, 0, 1'b0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
